inst_fetch_stage: RTL and testbench

- Instruction fetch stage at the head of the CPU pipeline. Drives word addresses to a synchronous instruction memory and buffers the returned instructions with their PCs in a small prefetch FIFO.
- Presents the FIFO head to the IF/ID pipe register as pc/inst/inst_valid.
- Honours downstream stall, branch redirects from EXE, and a halt request from decode.

---
 rtl/inst_fetch_stage.sv | 155 +++++++++++++++
 tb/tb_inst_fetch_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: issues word reads to a synchronous instruction memory and
// buffers {pc, inst} in a prefetch FIFO whose head feeds the IF/ID register.
module inst_fetch_stage #(
  parameter int                ADDR_W     = 16,
  parameter int                INST_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_to_new,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic              halt,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              fsm_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] fetch_pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] tag_addr_q;
  logic              tag_epoch_q;
  logic              epoch_q;
  logic              epoch_d;

  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [ADDR_W-1:0] pc_buf   [FIFO_DEPTH];
  logic [INST_W-1:0] inst_buf [FIFO_DEPTH];

  logic              run_ok;
  logic              halt_block;
  logic              credit_ok;
  logic [CNT_W:0]    credit_sum;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              push;
  logic              pop;
  logic              fifo_nonempty;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; a redirect always wins over halt
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (halt && !branch_to_new) state_d = S_HALTED;
      S_HALTED: if (branch_to_new)          state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run_ok    = (state_q == S_RUN);
    fsm_state = state_q;
  end

  // In-flight read counts against capacity, so the response push never overflows.
  assign credit_sum = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok  = (credit_sum < DEPTH_SUM);
  assign halt_block = halt & ~branch_to_new;
  assign issue      = ~rst & (run_ok | branch_to_new) & ~halt_block
                    & (credit_ok | branch_to_new);
  assign issue_addr = branch_to_new ? branch_pc : fetch_pc_q;

  assign imem_rd_en = issue;
  assign imem_addr  = rst ? '0 : issue_addr;

  // A redirect flips the epoch, so a response tagged before it no longer matches.
  assign epoch_d = epoch_q ^ branch_to_new;
  assign push    = inflight_q & (tag_epoch_q == epoch_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      inflight_q  <= 1'b0;
      tag_addr_q  <= '0;
      tag_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
    end else begin
      epoch_q    <= epoch_d;
      inflight_q <= issue;
      if (issue) begin
        fetch_pc_q  <= issue_addr + ADDR_W'(1);
        tag_addr_q  <= issue_addr;
        tag_epoch_q <= epoch_d;
      end
    end
  end

  // Handshake: the head entry transfers to IF/ID in a cycle where inst_valid=1 and
  // stall=0; while stall=1 the head (pc/inst) is held unchanged.
  assign fifo_nonempty = (count_q != '0);
  assign inst_valid    = ~rst & fifo_nonempty & ~branch_to_new;
  assign pop           = inst_valid & ~stall;
  assign pc            = inst_valid ? pc_buf[rd_ptr_q]   : '0;
  assign inst          = inst_valid ? inst_buf[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (rst || branch_to_new) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !branch_to_new) begin
      pc_buf[wr_ptr_q]   <= tag_addr_q;
      inst_buf[wr_ptr_q] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= DEPTH_CNT);
      assert (!(push && !pop && !branch_to_new && (count_q == DEPTH_CNT)));
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch stage.
module tb_inst_fetch_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_to_new = 1'b0;
  logic [15:0] branch_pc = '0;
  logic        halt = 1'b0;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        inst_valid;
  logic        fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [15:0] m_fetch_pc;
  bit          m_halted;
  logic [15:0] m_q[$];
  bit          m_fly;
  logic [15:0] m_fly_addr;
  logic        e_rd_en, e_valid, e_state;
  logic [15:0] e_addr, e_pc, e_inst;

  inst_fetch_stage #(
    .ADDR_W(16), .INST_W(16), .FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_to_new(branch_to_new),
    .branch_pc(branch_pc), .halt(halt), .imem_rd_en(imem_rd_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc), .inst(inst),
    .inst_valid(inst_valid), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  // synchronous instruction memory, one-cycle read latency
  always @(posedge clk) imem_rdata <= imem_rd_en ? mem_word(imem_addr) : 16'hDEAD;

  task automatic model_expect();
    int occ;
    occ = m_q.size() + (m_fly ? 1 : 0);
    e_rd_en = 1'b0; e_addr = '0; e_valid = 1'b0; e_pc = '0; e_inst = '0;
    e_state = m_halted;
    if (!rst) begin
      e_rd_en = branch_to_new || (!m_halted && !halt && occ < DEPTH);
      e_addr  = branch_to_new ? branch_pc : m_fetch_pc;
      e_valid = (m_q.size() != 0) && !branch_to_new;
      if (e_valid) begin
        e_pc   = m_q[0];
        e_inst = mem_word(m_q[0]);
      end
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_fetch_pc = 16'h0000;
      m_halted   = 1'b0;
      m_q.delete();
      m_fly      = 1'b0;
      m_fly_addr = '0;
    end else begin
      if (branch_to_new) begin
        m_q.delete();
      end else begin
        if (e_valid && !stall) m_q.delete(0);
        if (m_fly) m_q.push_back(m_fly_addr);
      end
      m_fly      = e_rd_en;
      m_fly_addr = e_addr;
      if (e_rd_en) m_fetch_pc = e_addr + 16'h0001;
      if (branch_to_new) m_halted = 1'b0;
      else if (halt)     m_halted = 1'b1;
    end
  endtask

  // one cycle: retire the previous cycle in the model, apply new inputs, settle
  task automatic drive(input bit r, input bit br, input logic [15:0] bpc,
                       input bit h, input bit s);
    @(negedge clk);
    model_step();
    rst = r; branch_to_new = br; branch_pc = bpc; halt = h; stall = s;
    #2;
    model_expect();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 16'h0, 0, 0);
      n_checks++;
      if ({imem_rd_en, imem_addr, inst_valid, pc, inst} !== 50'b0)
        $display("FAIL reset_outputs[%0d]: got %h required 0", k,
                 {imem_rd_en, imem_addr, inst_valid, pc, inst});
      else n_pass++;
    end
    n_checks++;
    if (fsm_state !== 1'b0) $display("FAIL reset_state: got %b required 0", fsm_state);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [32:0] exp_out;
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 16'h0, 0, 0);
      n_checks++;
      if ({imem_rd_en, imem_addr} !== {1'b1, 16'(k)})
        $display("FAIL stream_fetch[%0d]: got %h required %h", k, {imem_rd_en, imem_addr}, {1'b1, 16'(k)});
      else n_pass++;
      exp_out = (k >= 2) ? {1'b1, 16'(k - 2), 16'(k - 2 + 'h1000)} : 33'b0;
      n_checks++;
      if ({inst_valid, pc, inst} !== exp_out)
        $display("FAIL stream_out[%0d]: got %h required %h", k, {inst_valid, pc, inst}, exp_out);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    for (int j = 0; j < 10; j++) begin
      drive(0, 0, 16'h0, 0, 1);
      n_checks++;
      if ({inst_valid, pc, inst} !== {1'b1, 16'h0005, 16'h1005})
        $display("FAIL stall_hold[%0d]: got %h required %h", j, {inst_valid, pc, inst}, {1'b1, 16'h0005, 16'h1005});
      else n_pass++;
      n_checks++;
      if (imem_rd_en !== (j < 2))
        $display("FAIL stall_rd_en[%0d]: got %b required %b", j, imem_rd_en, (j < 2));
      else n_pass++;
    end
    for (int j = 0; j < 5; j++) begin
      drive(0, 0, 16'h0, 0, 0);
      n_checks++;
      if ({inst_valid, pc} !== {1'b1, 16'(5 + j)})
        $display("FAIL stall_drain[%0d]: got %h required %h", j, {inst_valid, pc}, {1'b1, 16'(5 + j)});
      else n_pass++;
      if (j == 1) begin
        n_checks++;
        if ({imem_rd_en, imem_addr} !== {1'b1, 16'h0009})
          $display("FAIL stall_refetch: got %h required %h", {imem_rd_en, imem_addr}, {1'b1, 16'h0009});
        else n_pass++;
      end
    end
  endtask

  task automatic test_branch();
    drive(0, 1, 16'h0040, 0, 0);
    n_checks++;
    if ({inst_valid, imem_rd_en, imem_addr} !== {1'b0, 1'b1, 16'h0040})
      $display("FAIL branch_t: got %h required %h", {inst_valid, imem_rd_en, imem_addr}, {1'b0, 1'b1, 16'h0040});
    else n_pass++;
    drive(0, 0, 16'h0, 0, 0);
    n_checks++;
    if ({inst_valid, imem_addr} !== {1'b0, 16'h0041})
      $display("FAIL branch_t1: got %h required %h", {inst_valid, imem_addr}, {1'b0, 16'h0041});
    else n_pass++;
    for (int j = 0; j < 2; j++) begin
      drive(0, 0, 16'h0, 0, 0);
      n_checks++;
      if ({inst_valid, pc, inst} !== {1'b1, 16'(16'h0040 + j), 16'(16'h1040 + j)})
        $display("FAIL branch_target[%0d]: got %h required %h", j, {inst_valid, pc, inst},
                 {1'b1, 16'(16'h0040 + j), 16'(16'h1040 + j)});
      else n_pass++;
    end
  endtask

  task automatic test_branch_stall_halt();
    drive(0, 1, 16'h0080, 1, 1);
    n_checks++;
    if ({inst_valid, imem_rd_en, imem_addr} !== {1'b0, 1'b1, 16'h0080})
      $display("FAIL bsh_issue: got %h required %h", {inst_valid, imem_rd_en, imem_addr}, {1'b0, 1'b1, 16'h0080});
    else n_pass++;
    drive(0, 0, 16'h0, 0, 0);
    n_checks++;
    if ({fsm_state, inst_valid} !== 2'b00)
      $display("FAIL bsh_state: got %b required 00", {fsm_state, inst_valid});
    else n_pass++;
    drive(0, 0, 16'h0, 0, 0);
    n_checks++;
    if ({inst_valid, pc} !== {1'b1, 16'h0080})
      $display("FAIL bsh_target: got %h required %h", {inst_valid, pc}, {1'b1, 16'h0080});
    else n_pass++;
  endtask

  task automatic test_halt();
    logic [16:0] exp_out;
    drive(0, 1, 16'h0000, 0, 0);
    for (int k = 1; k < 8; k++) drive(0, 0, 16'h0, 0, 0);
    for (int j = 0; j < 10; j++) begin
      drive(0, 0, 16'h0, (j == 0), 0);
      n_checks++;
      if (imem_rd_en !== 1'b0) $display("FAIL halt_no_fetch[%0d]: got %b required 0", j, imem_rd_en);
      else n_pass++;
      exp_out = (j < 2) ? {1'b1, 16'(6 + j)} : 17'b0;
      n_checks++;
      if ({inst_valid, pc} !== exp_out)
        $display("FAIL halt_drain[%0d]: got %h required %h", j, {inst_valid, pc}, exp_out);
      else n_pass++;
      n_checks++;
      if (fsm_state !== (j >= 1)) $display("FAIL halt_state[%0d]: got %b required %b", j, fsm_state, (j >= 1));
      else n_pass++;
    end
    drive(0, 1, 16'h0010, 0, 0);
    n_checks++;
    if ({imem_rd_en, imem_addr} !== {1'b1, 16'h0010})
      $display("FAIL halt_wake_issue: got %h required %h", {imem_rd_en, imem_addr}, {1'b1, 16'h0010});
    else n_pass++;
    drive(0, 0, 16'h0, 0, 0);
    drive(0, 0, 16'h0, 0, 0);
    n_checks++;
    if ({fsm_state, inst_valid, pc, inst} !== {1'b0, 1'b1, 16'h0010, 16'h1010})
      $display("FAIL halt_wake_out: got %h required %h", {fsm_state, inst_valid, pc, inst},
               {1'b0, 1'b1, 16'h0010, 16'h1010});
    else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    logic [15:0] exp_pc;
    drive(0, 1, 16'hFFFE, 0, 0);
    drive(0, 0, 16'h0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 16'h0, 0, 0);
      exp_pc = 16'hFFFE + 16'(j);
      n_checks++;
      if ({inst_valid, pc, inst} !== {1'b1, exp_pc, mem_word(exp_pc)})
        $display("FAIL wrap_pc[%0d]: got %h required %h", j, {inst_valid, pc, inst}, {1'b1, exp_pc, mem_word(exp_pc)});
      else n_pass++;
    end
    drive(1, 0, 16'h0, 0, 0);
    n_checks++;
    if ({imem_rd_en, imem_addr, inst_valid, pc, inst} !== 50'b0)
      $display("FAIL midrst_outputs: got %h required 0", {imem_rd_en, imem_addr, inst_valid, pc, inst});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 16'h0, 0, 0);
      n_checks++;
      if ({imem_rd_en, imem_addr} !== {1'b1, 16'(k)})
        $display("FAIL midrst_fetch[%0d]: got %h required %h", k, {imem_rd_en, imem_addr}, {1'b1, 16'(k)});
      else n_pass++;
      n_checks++;
      if ({inst_valid, pc, inst} !== ((k == 2) ? {1'b1, 16'h0000, 16'h1000} : 33'b0))
        $display("FAIL midrst_out[%0d]: got %h required %h", k, {inst_valid, pc, inst},
                 ((k == 2) ? {1'b1, 16'h0000, 16'h1000} : 33'b0));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit          r, br, h, s;
    logic [15:0] bpc;
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 99) < 2);
      br  = ($urandom_range(0, 99) < 10);
      h   = ($urandom_range(0, 99) < 8);
      s   = ($urandom_range(0, 99) < 35);
      bpc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF))
                                        : 16'($urandom_range(0, 65535));
      drive(r, br, bpc, h, s);
      n_checks++;
      if (imem_rd_en !== e_rd_en) $display("FAIL rand_rd_en[%0d]: got %b required %b", c, imem_rd_en, e_rd_en);
      else n_pass++;
      n_checks++;
      if (imem_addr !== e_addr) $display("FAIL rand_addr[%0d]: got %h required %h", c, imem_addr, e_addr);
      else n_pass++;
      n_checks++;
      if (inst_valid !== e_valid) $display("FAIL rand_valid[%0d]: got %b required %b", c, inst_valid, e_valid);
      else n_pass++;
      n_checks++;
      if ({pc, inst} !== {e_pc, e_inst})
        $display("FAIL rand_pc_inst[%0d]: got %h required %h", c, {pc, inst}, {e_pc, e_inst});
      else n_pass++;
      n_checks++;
      if (fsm_state !== e_state) $display("FAIL rand_state[%0d]: got %b required %b", c, fsm_state, e_state);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_stall_halt();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
